// File: rtl/elastic_pipe_reg.sv
// elastic_pipe_reg: DEPTH-stage valid/ready elastic pipeline with bubble collapse, flush and occupancy.
// Define ELASTIC_PIPE_KILL_EN to add the per-stage killMask input.
module elastic_pipe_reg #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         resetN,
  input  logic                         flush,
  input  logic                         inValid,
  output logic                         inReady,
  input  logic [WIDTH-1:0]             inData,
  output logic                         outValid,
  input  logic                         outReady,
  output logic [WIDTH-1:0]             outData,
  output logic [$clog2(DEPTH+1)-1:0]   occupancy
`ifdef ELASTIC_PIPE_KILL_EN
  ,
  input  logic [DEPTH-1:0]             killMask
`endif
);
  localparam int OW = $clog2(DEPTH+1);
  logic [DEPTH-1:0] r_vld;
  logic [WIDTH-1:0] r_dat [DEPTH];
  logic [OW-1:0]    r_occ;
  logic [DEPTH-1:0] w_mv, w_ld, w_kill, w_vld_nxt;
  logic [WIDTH-1:0] w_src [DEPTH];
  logic [OW-1:0]    w_occ_nxt;
`ifdef ELASTIC_PIPE_KILL_EN
  assign w_kill = killMask;
`else
  assign w_kill = '0;
`endif
  // Move chain runs from the output side back, so a draining stage frees its predecessor.
  always_comb begin
    w_mv = '0;
    w_mv[DEPTH-1] = r_vld[DEPTH-1] & outReady & ~flush;
    for (int i = DEPTH-2; i >= 0; i--)
      w_mv[i] = r_vld[i] & (~r_vld[i+1] | w_mv[i+1]) & ~flush;
  end
  assign inReady  = resetN & ~flush & (~r_vld[0] | w_mv[0]);
  assign outValid = r_vld[DEPTH-1] & ~flush & ~w_kill[DEPTH-1];
  assign outData  = r_dat[DEPTH-1];
  assign occupancy = r_occ;
  // A killed payload leaving stage i-1 never lands in stage i; the kill only clears old contents.
  always_comb begin
    w_ld = '0;
    w_ld[0] = inValid & inReady;
    w_src[0] = inData;
    for (int i = 1; i < DEPTH; i++) begin
      w_ld[i] = w_mv[i-1] & ~w_kill[i-1];
      w_src[i] = r_dat[i-1];
    end
    w_vld_nxt = w_ld | (r_vld & ~w_mv & ~w_kill);
    w_occ_nxt = '0;
    for (int i = 0; i < DEPTH; i++)
      w_occ_nxt = w_occ_nxt + OW'(w_vld_nxt[i]);
  end
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_vld <= '0;
      r_occ <= '0;
      for (int i = 0; i < DEPTH; i++) r_dat[i] <= '0;
    end else if (flush) begin
      r_vld <= '0;
      r_occ <= '0;
      for (int i = 0; i < DEPTH; i++) r_dat[i] <= '0;
    end else begin
      r_vld <= w_vld_nxt;
      r_occ <= w_occ_nxt;
      for (int i = 0; i < DEPTH; i++)
        if (w_ld[i]) r_dat[i] <= w_src[i];
    end
  end
endmodule

// File: tb/tb_elastic_pipe_reg.sv
// tb_elastic_pipe_reg: DEPTH 1..4 instances on shared stimulus; directed tables plus a random run
// against a payload-position model of the pipeline.
module tb_elastic_pipe_reg;
  logic clk = 0, resetN = 0, fl = 0, iv = 0, ordy = 0;
  logic [31:0] din = 0;
  logic ir_a [4], ov_a [4];
  logic [31:0] od_a [4];
  logic [0:0] occ1;
  logic [1:0] occ2, occ3;
  logic [2:0] occ4;
`ifdef ELASTIC_PIPE_KILL_EN
  logic [3:0] km = 0;
`endif
  int n_cmp = 0, n_bad = 0;
  int mn [4];
  int mpos [4][8];
  logic [31:0] mdat [4][8];
  logic [31:0] mlast [4];
  int p_np [8];
  bit p_drop, p_rdy;

  always #5 clk = ~clk;

`ifdef ELASTIC_PIPE_KILL_EN
  `define KM(n) , .killMask(km[n-1:0])
`else
  `define KM(n)
`endif
  elastic_pipe_reg #(.WIDTH(32), .DEPTH(1)) u1 (.clk(clk), .resetN(resetN), .flush(fl), .inValid(iv),
    .inReady(ir_a[0]), .inData(din), .outValid(ov_a[0]), .outReady(ordy), .outData(od_a[0]), .occupancy(occ1) `KM(1));
  elastic_pipe_reg #(.WIDTH(32), .DEPTH(2)) u2 (.clk(clk), .resetN(resetN), .flush(fl), .inValid(iv),
    .inReady(ir_a[1]), .inData(din), .outValid(ov_a[1]), .outReady(ordy), .outData(od_a[1]), .occupancy(occ2) `KM(2));
  elastic_pipe_reg #(.WIDTH(32), .DEPTH(3)) u3 (.clk(clk), .resetN(resetN), .flush(fl), .inValid(iv),
    .inReady(ir_a[2]), .inData(din), .outValid(ov_a[2]), .outReady(ordy), .outData(od_a[2]), .occupancy(occ3) `KM(3));
  elastic_pipe_reg #(.WIDTH(32), .DEPTH(4)) u4 (.clk(clk), .resetN(resetN), .flush(fl), .inValid(iv),
    .inReady(ir_a[3]), .inData(din), .outValid(ov_a[3]), .outReady(ordy), .outData(od_a[3]), .occupancy(occ4) `KM(4));

  function automatic int occ_of(input int k);
    return k == 0 ? int'(occ1) : k == 1 ? int'(occ2) : k == 2 ? int'(occ3) : int'(occ4);
  endfunction

  task automatic chk(input string tag, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Drive one cycle's inputs, check combinational/registered outputs (-1 = don't care), advance to next negedge.
  task automatic cyc(input int k, input logic v, input logic [31:0] d, input logic r, input logic f,
                     input int e_ir, input int e_ov, input int e_od, input int e_occ, input string tag);
    iv = v; din = d; ordy = r; fl = f;
    #1;
    if (e_ir >= 0) chk({tag, " inReady"}, int'(ir_a[k]), e_ir);
    if (e_ov >= 0) chk({tag, " outValid"}, int'(ov_a[k]), e_ov);
    if (e_od >= 0) chk({tag, " outData"}, int'(od_a[k]), e_od);
    if (e_occ >= 0) chk({tag, " occupancy"}, occ_of(k), e_occ);
    @(negedge clk);
  endtask

  task automatic do_reset();
    resetN = 0; iv = 0; fl = 0; ordy = 0; din = 0;
    @(negedge clk);
    #1;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("reset d%0d inReady", k+1), int'(ir_a[k]), 0);
      chk($sformatf("reset d%0d outValid", k+1), int'(ov_a[k]), 0);
      chk($sformatf("reset d%0d occupancy", k+1), occ_of(k), 0);
    end
    @(negedge clk);
    resetN = 1;
    for (int k = 0; k < 4; k++) begin mn[k] = 0; mlast[k] = 0; end
  endtask

  // Model: ordered list of payloads with their stage positions; the oldest may leave from the
  // last stage, every other payload steps forward unless the one ahead of it still blocks.
  task automatic plan(input int k);
    int lim;
    lim = k + 1;
    p_drop = 0;
    for (int j = 0; j < mn[k]; j++) begin
      if (j == 0 && mpos[k][0] == k && ordy) begin
        p_drop = 1;
        p_np[0] = k + 1;
      end else begin
        p_np[j] = (mpos[k][j] + 1 < lim - 1) ? mpos[k][j] + 1 : lim - 1;
        lim = p_np[j];
      end
    end
    p_rdy = !fl && (mn[k] == 0 || p_np[mn[k]-1] > 0);
  endtask

  task automatic step(input int k);
    int m;
    plan(k);
    m = 0;
    if (fl) begin
      mn[k] = 0;
      mlast[k] = 0;
    end else begin
      for (int j = p_drop ? 1 : 0; j < mn[k]; j++) begin
        mpos[k][m] = p_np[j];
        mdat[k][m] = mdat[k][j];
        m++;
      end
      if (iv && p_rdy) begin
        mpos[k][m] = 0;
        mdat[k][m] = din;
        m++;
      end
      mn[k] = m;
      if (m > 0 && mpos[k][0] == k) mlast[k] = mdat[k][0];
    end
  endtask

  typedef struct {
    logic v; logic [31:0] d; logic r; logic f;
    int e_ir; int e_ov; int e_od; int e_occ;
  } vec_t;
  vec_t tv [7];

  initial begin
    tv[0] = '{1'b1, 32'h11, 1'b1, 1'b0, 1, 0, 0, 0};
    tv[1] = '{1'b1, 32'h22, 1'b1, 1'b0, 1, 0, 0, 1};
    tv[2] = '{1'b1, 32'h33, 1'b1, 1'b0, 1, 0, 0, 2};
    tv[3] = '{1'b0, 32'h0,  1'b1, 1'b0, 1, 1, 'h11, 3};
    tv[4] = '{1'b0, 32'h0,  1'b1, 1'b0, 1, 1, 'h22, 2};
    tv[5] = '{1'b0, 32'h0,  1'b1, 1'b0, 1, 1, 'h33, 1};
    tv[6] = '{1'b0, 32'h0,  1'b1, 1'b0, 1, 0, 'h33, 0};

    do_reset();
    for (int i = 0; i < 7; i++)
      cyc(2, tv[i].v, tv[i].d, tv[i].r, tv[i].f, tv[i].e_ir, tv[i].e_ov, tv[i].e_od, tv[i].e_occ,
          $sformatf("lat[%0d]", i));

    // Reset mid-stream, DEPTH=3
    do_reset();
    cyc(2, 1, 32'h1, 0, 0, 1, 0, -1, 0, "rst fill0");
    cyc(2, 1, 32'h2, 0, 0, 1, 0, -1, 1, "rst fill1");
    cyc(2, 1, 32'h3, 0, 0, 1, 0, -1, 2, "rst fill2");
    iv = 0;
    #1 chk("rst full outValid", int'(ov_a[2]), 1);
    #1 resetN = 0;
    #1;
    chk("rst async outValid", int'(ov_a[2]), 0);
    chk("rst async occupancy", occ_of(2), 0);
    chk("rst async outData", int'(od_a[2]), 0);
    chk("rst async inReady", int'(ir_a[2]), 0);
    #1 resetN = 1;
    #1 chk("rst release inReady", int'(ir_a[2]), 1);
    @(negedge clk);

    // Backpressure, DEPTH=2
    do_reset();
    cyc(1, 1, 32'hA, 0, 0, 1, 0, -1, 0, "bp A");
    cyc(1, 1, 32'hB, 0, 0, 1, 0, -1, 1, "bp B");
    cyc(1, 1, 32'hC, 0, 0, 0, 1, 'hA, 2, "bp C refused");
    cyc(1, 1, 32'hC, 1, 0, 1, 1, 'hA, 2, "bp C retry");
    cyc(1, 0, 32'h0, 1, 0, 1, 1, 'hB, 2, "bp out B");
    cyc(1, 0, 32'h0, 1, 0, 1, 1, 'hC, 1, "bp out C");
    cyc(1, 0, 32'h0, 1, 0, 1, 0, -1, 0, "bp empty");

    // Bubble collapse, DEPTH=4
    do_reset();
    cyc(3, 1, 32'h5, 0, 0, 1, 0, -1, 0, "bub push5");
    for (int i = 0; i < 3; i++) cyc(3, 0, 32'h0, 0, 0, 1, 0, -1, 1, "bub travel");
    cyc(3, 1, 32'h6, 0, 0, 1, 1, 'h5, 1, "bub push6");
    cyc(3, 0, 32'h0, 0, 0, 1, 1, 'h5, 2, "bub hold1");
    cyc(3, 0, 32'h0, 0, 0, 1, 1, 'h5, 2, "bub hold2");
    cyc(3, 0, 32'h0, 1, 0, 1, 1, 'h5, 2, "bub drain5");
    cyc(3, 0, 32'h0, 1, 0, 1, 1, 'h6, 1, "bub next6");

    // Flush with simultaneous input, DEPTH=2
    do_reset();
    cyc(1, 1, 32'hA0, 0, 0, 1, 0, -1, 0, "fl fill0");
    cyc(1, 1, 32'hA1, 0, 0, 1, 0, -1, 1, "fl fill1");
    cyc(1, 1, 32'h99, 0, 1, 0, 0, -1, 2, "fl flush");
    cyc(1, 0, 32'h0, 0, 0, 1, 0, 0, 0, "fl after");

`ifdef ELASTIC_PIPE_KILL_EN
    do_reset();
    cyc(2, 1, 32'h1, 0, 0, 1, 0, -1, 0, "kill fill0");
    cyc(2, 1, 32'h2, 0, 0, 1, 0, -1, 1, "kill fill1");
    cyc(2, 1, 32'h3, 0, 0, 1, 0, -1, 2, "kill fill2");
    km = 4'b0010;
    cyc(2, 0, 32'h0, 1, 0, 1, 1, 'h1, 3, "kill edge");
    km = 4'b0000;
    cyc(2, 0, 32'h0, 1, 0, 1, 0, -1, 1, "kill after");
    cyc(2, 0, 32'h0, 1, 0, 1, 1, 'h3, 1, "kill out3");
    cyc(2, 0, 32'h0, 1, 0, 1, 0, -1, 0, "kill empty");
`endif

    // Random traffic on all depths against the position model
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      iv = $urandom_range(0, 3) != 0;
      ordy = $urandom_range(0, 3) != 0;
      fl = $urandom_range(0, 39) == 0;
      din = $urandom;
      #1;
      for (int k = 0; k < 4; k++) begin
        plan(k);
        chk($sformatf("rnd d%0d c%0d inReady", k+1, c), int'(ir_a[k]), int'(p_rdy));
        chk($sformatf("rnd d%0d c%0d outValid", k+1, c), int'(ov_a[k]),
            int'(!fl && mn[k] > 0 && mpos[k][0] == k));
        chk($sformatf("rnd d%0d c%0d outData", k+1, c), int'(od_a[k]), int'(mlast[k]));
        chk($sformatf("rnd d%0d c%0d occupancy", k+1, c), occ_of(k), mn[k]);
        step(k);
      end
      @(negedge clk);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
